// File: rtl/bpu_pkg.sv
// Shared encodings for the fetch-stage branch predictor: resolution types,
// 2-bit counter states, controller states and the counter update rule.
package bpu_pkg;

   typedef enum logic [1:0] {
      UPD_BR   = 2'd0,
      UPD_JAL  = 2'd1,
      UPD_CALL = 2'd2,
      UPD_RET  = 2'd3
   } upd_type_e;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bpu_state_e;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
      else       return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack: circular buffer whose push overwrites the oldest entry
// when full; pop on an empty stack does nothing.
module bpu_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [XLEN-1:0]            push_data,
   output logic [XLEN-1:0]            top,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;

   // NOTE: storage has no reset; only ptr/count define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr   <= ptr + PW'(1);
         count <= (count == (PW+1)'(DEPTH)) ? count : count + (PW+1)'(1);
      end else if (pop && count != '0) begin
         ptr   <= ptr - PW'(1);
         count <= count - (PW+1)'(1);
      end
   end

   assign top = mem[ptr - PW'(1)];

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage predictor: direct-mapped BTB, gshare 2-bit BHT and a return-address
// stack, looked up one cycle ahead of decode and trained by decode-stage resolution.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 64,
   parameter int BHT_ENTRIES = 256,
   parameter int GHR_BITS    = 8,
   parameter int RAS_DEPTH   = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ready,
   input  logic            fetch_valid,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            stall,
   input  logic            flush,
   output logic            pred_valid,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [1:0]      upd_type,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int BHT_IW = $clog2(BHT_ENTRIES);
   localparam int TAG_W  = XLEN - 2 - BTB_IW;
   localparam int RAS_CW = $clog2(RAS_DEPTH) + 1;

   bpu_state_e state_q, state_d;
   logic [BHT_IW-1:0] init_idx;
   logic [GHR_BITS-1:0] ghr;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
   upd_type_e              btb_type   [BTB_ENTRIES];
   logic [1:0]             bht        [BHT_ENTRIES];

   logic [XLEN-1:0]   ras_top;
   logic [RAS_CW-1:0] ras_count;

   // ---------------- init sweep controller ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= INIT;
         init_idx <= '0;
      end else begin
         state_q  <= state_d;
         if (state_q == INIT) init_idx <= init_idx + BHT_IW'(1);
      end
   end

   // NOTE: next-state defaults come first so no path through the block infers a latch.
   always_comb begin
      state_d = state_q;
      if (state_q == INIT && init_idx == BHT_IW'(BHT_ENTRIES - 1)) state_d = RUN;
   end

   assign ready = (state_q == RUN);

   // ---------------- lookup ----------------
   logic [BTB_IW-1:0] f_bidx;
   logic [BHT_IW-1:0] f_hidx;
   logic              f_hit;
   logic [XLEN-1:0]   f_seq;
   logic              look_taken;
   logic [XLEN-1:0]   look_target;

   assign f_bidx = fetch_pc[2 +: BTB_IW];
   assign f_hidx = fetch_pc[2 +: BHT_IW] ^ BHT_IW'(ghr);
   assign f_hit  = btb_valid[f_bidx] && (btb_tag[f_bidx] == fetch_pc[XLEN-1 -: TAG_W]);
   assign f_seq  = fetch_pc + XLEN'(4);

   always_comb begin
      look_taken  = 1'b0;
      look_target = f_seq;
      if (f_hit) begin
         case (btb_type[f_bidx])
            UPD_BR: begin
               if (bht[f_hidx][1]) begin
                  look_taken  = 1'b1;
                  look_target = btb_target[f_bidx];
               end
            end
            UPD_JAL, UPD_CALL: begin
               look_taken  = 1'b1;
               look_target = btb_target[f_bidx];
            end
            UPD_RET: begin
               look_taken  = 1'b1;
               look_target = (ras_count != '0) ? ras_top : btb_target[f_bidx];
            end
            default: ;
         endcase
      end
   end

   // Flush wins over stall; stall freezes the whole prediction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
      end else if (flush) begin
         pred_valid  <= 1'b0;
      end else if (!stall) begin
         pred_valid  <= fetch_valid && ready;
         if (fetch_valid && ready) begin
            pred_taken  <= look_taken;
            pred_target <= look_target;
         end
      end
   end

   // ---------------- update ----------------
   logic              upd_en;
   logic              upd_br;
   logic              btb_we;
   logic [BTB_IW-1:0] u_bidx;
   logic [BHT_IW-1:0] u_hidx;

   assign upd_en = upd_valid && ready;
   assign upd_br = upd_en && (upd_type == UPD_BR);
   assign btb_we = upd_en && ((upd_type != UPD_BR) || upd_taken);
   assign u_bidx = upd_pc[2 +: BTB_IW];
   assign u_hidx = upd_pc[2 +: BHT_IW] ^ BHT_IW'(ghr);

   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag[u_bidx]    <= upd_pc[XLEN-1 -: TAG_W];
         btb_target[u_bidx] <= upd_target;
         btb_type[u_bidx]   <= upd_type_e'(upd_type);
      end
      if (state_q == INIT)  bht[init_idx] <= WNT;
      else if (upd_br)      bht[u_hidx]   <= sat_update(bht[u_hidx], upd_taken);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_valid <= '0;
         ghr       <= '0;
      end else begin
         if (btb_we) btb_valid[u_bidx] <= 1'b1;
         if (upd_br) ghr <= {ghr[GHR_BITS-2:0], upd_taken};
      end
   end

   bpu_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (upd_en && (upd_type == UPD_CALL)),
      .pop       (upd_en && (upd_type == UPD_RET)),
      .push_data (upd_pc + XLEN'(4)),
      .top       (ras_top),
      .count     (ras_count)
   );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;
   import bpu_pkg::*;

   logic        clk;
   logic        rst;
   logic        ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        stall;
   logic        flush;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [1:0]  upd_type;
   logic        upd_taken;
   logic [31:0] upd_target;

   int checks   = 0;
   int failures = 0;

   branch_predict_unit dut (
      .clk         (clk),
      .rst         (rst),
      .ready       (ready),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .stall       (stall),
      .flush       (flush),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_type    (upd_type),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                      input logic [31:0] tgt);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_type   = typ;
      upd_taken  = tk;
      upd_target = tgt;
      step();
      upd_valid  = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      step();
      fetch_valid = 1'b0;
   endtask

   task automatic check_pred(input string tag, input logic tk, input logic [31:0] tgt);
      check({tag, "_valid"}, 32'(pred_valid), 32'd1);
      check({tag, "_taken"}, 32'(pred_taken), 32'(tk));
      check({tag, "_target"}, pred_target, tgt);
   endtask

   // Eight not-taken branches at 0x404 return ghr to zero without touching BHT entry 0x80.
   task automatic ghr_clear();
      for (int i = 0; i < 8; i++) upd(32'h404, UPD_BR, 1'b0, 32'h0);
   endtask

   int n;

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      flush       = 1'b0;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      upd_valid   = 1'b1;
      upd_pc      = 32'h100;
      upd_type    = UPD_CALL;
      upd_taken   = 1'b1;
      upd_target  = 32'h777;
      repeat (3) step();
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_pred_valid", 32'(pred_valid), 32'd0);
      check("rst_pred_taken", 32'(pred_taken), 32'd0);
      check("rst_pred_target", pred_target, 32'h0);

      // Sweep interrupted at cycle 100; fetches and CALL updates must be ignored throughout.
      rst = 1'b0;
      repeat (100) step();
      check("init_ready", 32'(ready), 32'd0);
      check("init_pred_valid", 32'(pred_valid), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      while (!ready && n < 1000) begin
         step();
         n++;
      end
      check("init_cycles", 32'(n), 32'd256);
      upd_valid   = 1'b0;
      fetch_valid = 1'b0;

      // Cold lookup: INIT-time CALL at 0x100 must not have allocated.
      lookup(32'h100);
      check_pred("cold_100", 1'b0, 32'h104);
      step();
      check("idle_pred_valid", 32'(pred_valid), 32'd0);

      // RET with empty RAS falls back to the BTB target.
      upd(32'h300, UPD_RET, 1'b0, 32'h999);
      lookup(32'h300);
      check_pred("ret_empty", 1'b1, 32'h999);

      // RAS push/pop, overflow and empty-pop behaviour.
      upd(32'h10, UPD_CALL, 1'b0, 32'h1000);
      upd(32'h20, UPD_CALL, 1'b0, 32'h2000);
      lookup(32'h300);
      check_pred("ras_two", 1'b1, 32'h24);
      upd(32'h300, UPD_RET, 1'b0, 32'h999);
      lookup(32'h300);
      check_pred("ras_pop", 1'b1, 32'h14);
      for (int i = 0; i < 9; i++) upd(32'h40 + 32'(i) * 32'h10, UPD_CALL, 1'b0, 32'h3000);
      lookup(32'h300);
      check_pred("ras_nine", 1'b1, 32'hC4);
      upd(32'h300, UPD_RET, 1'b0, 32'h999);
      lookup(32'h300);
      check_pred("ras_full_pop", 1'b1, 32'hB4);
      for (int i = 0; i < 7; i++) upd(32'h300, UPD_RET, 1'b0, 32'h999);
      lookup(32'h300);
      check_pred("ras_drained", 1'b1, 32'h999);
      upd(32'h300, UPD_RET, 1'b0, 32'h999);
      upd(32'hD0, UPD_CALL, 1'b0, 32'h3000);
      upd(32'h300, UPD_RET, 1'b0, 32'h999);
      upd(32'hE0, UPD_CALL, 1'b0, 32'h3000);
      lookup(32'h300);
      check_pred("ras_after_empty_pop", 1'b1, 32'hE4);

      // Gshare BR at 0x200: counter at index 0x80 climbs WNT->WT->ST->ST.
      upd(32'h200, UPD_BR, 1'b1, 32'h180);
      ghr_clear();
      lookup(32'h200);
      check_pred("br_wt", 1'b1, 32'h180);
      upd(32'h200, UPD_BR, 1'b1, 32'h180);
      ghr_clear();
      lookup(32'h200);
      check_pred("br_st", 1'b1, 32'h180);
      upd(32'h200, UPD_BR, 1'b1, 32'h180);
      ghr_clear();
      lookup(32'h200);
      check_pred("br_st_sat", 1'b1, 32'h180);

      // Not-taken BR aliasing the same BTB slot must not evict 0x200.
      upd(32'h100, UPD_BR, 1'b0, 32'h555);
      lookup(32'h200);
      check_pred("br_no_alloc", 1'b1, 32'h180);
      lookup(32'h100);
      check_pred("br_no_alloc_miss", 1'b0, 32'h104);

      // Decrement ST->WT, then same-cycle update/lookup sees WT, next lookup sees WNT.
      upd(32'h200, UPD_BR, 1'b0, 32'h180);
      lookup(32'h200);
      check_pred("br_wt_down", 1'b1, 32'h180);
      upd_valid   = 1'b1;
      upd_pc      = 32'h200;
      upd_type    = UPD_BR;
      upd_taken   = 1'b0;
      upd_target  = 32'h180;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h200;
      step();
      upd_valid   = 1'b0;
      fetch_valid = 1'b0;
      check_pred("br_same_cycle", 1'b1, 32'h180);
      lookup(32'h200);
      check_pred("br_wnt", 1'b0, 32'h204);
      upd(32'h200, UPD_BR, 1'b0, 32'h180);
      lookup(32'h200);
      check_pred("br_snt", 1'b0, 32'h204);
      upd(32'h200, UPD_BR, 1'b0, 32'h180);
      upd(32'h200, UPD_BR, 1'b1, 32'h180);
      ghr_clear();
      lookup(32'h200);
      check_pred("br_snt_sat", 1'b0, 32'h204);

      // Stall holds, flush (even with stall) drops pred_valid.
      lookup(32'h100);
      check_pred("pre_stall", 1'b0, 32'h104);
      stall       = 1'b1;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h300;
      for (int i = 0; i < 3; i++) begin
         step();
         check_pred("stall_hold", 1'b0, 32'h104);
      end
      flush = 1'b1;
      step();
      check("flush_stall_valid", 32'(pred_valid), 32'd0);
      flush       = 1'b0;
      stall       = 1'b0;
      fetch_valid = 1'b0;

      // pc+4 wraps to zero.
      lookup(32'hFFFF_FFFC);
      check_pred("wrap", 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
